// File: rtl/wb_watchdog.sv
// Two-stage Wishbone watchdog: the first timeout raises a bark interrupt, and a
// second unserviced timeout (or a kick with the wrong key) raises a latched reset request.
module wb_watchdog #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned PRESCALE = 1024,
    parameter logic [31:0] KEY      = 32'h5A5A_C3C3
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic [2:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        irq_o,
    output logic        wdt_rst_o
);

    localparam int unsigned     PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    localparam logic [2:0] ADR_CTRL   = 3'd0;
    localparam logic [2:0] ADR_LOAD   = 3'd1;
    localparam logic [2:0] ADR_COUNT  = 3'd2;
    localparam logic [2:0] ADR_KICK   = 3'd3;
    localparam logic [2:0] ADR_STATUS = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_BARKED,
        S_BITTEN
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic [WIDTH-1:0]  load_q, load_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic              bark_q, bark_d;
    logic              bite_q, bite_d;
    logic              irq_q, irq_d;
    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;

    logic              bus_req;
    logic              bus_wr;
    logic              bus_rd;
    logic              running;
    logic              tick;
    logic              locked;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
            load_q  <= '1;
            count_q <= '0;
            presc_q <= '0;
            bark_q  <= 1'b0;
            bite_q  <= 1'b0;
            irq_q   <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            count_q <= count_d;
            presc_q <= presc_d;
            bark_q  <= bark_d;
            bite_q  <= bite_d;
            irq_q   <= irq_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        load_d  = load_q;
        count_d = count_q;
        presc_d = presc_q;
        bark_d  = bark_q;
        bite_d  = bite_q;
        dat_d   = '0;

        bus_req = wb_cyc_i & wb_stb_i & ~ack_q;
        bus_wr  = bus_req & wb_we_i;
        bus_rd  = bus_req & ~wb_we_i;
        ack_d   = bus_req;
        locked  = ctrl_q[2];
        running = (state_q == S_RUN) || (state_q == S_BARKED);
        tick    = running && (presc_q == PRESC_MAX);

        if (running) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        if (tick) begin
            if (count_q <= CNT_ONE) begin
                count_d = load_q;
                if (state_q == S_RUN) begin
                    state_d = S_BARKED;
                    bark_d  = 1'b1;
                end else begin
                    state_d = S_BITTEN;
                    bite_d  = 1'b1;
                end
            end else begin
                count_d = count_q - CNT_ONE;
            end
        end

        // Bus writes are evaluated after the tick so a kick or disable on a tick edge wins.
        if (bus_wr) begin
            case (wb_adr_i)
                ADR_CTRL: begin
                    if (!locked) begin
                        ctrl_d = wb_dat_i[2:0];
                        if (state_q == S_IDLE && wb_dat_i[0]) begin
                            state_d = S_RUN;
                            count_d = load_q;
                            presc_d = '0;
                        end else if (running && !wb_dat_i[0]) begin
                            state_d = S_IDLE;
                            bark_d  = 1'b0;
                            count_d = count_q;
                            presc_d = presc_q;
                        end
                    end
                end
                ADR_LOAD: begin
                    if (!locked) begin
                        load_d = wb_dat_i[WIDTH-1:0];
                    end
                end
                ADR_KICK: begin
                    if (ctrl_q[0]) begin
                        if (wb_dat_i == KEY) begin
                            if (running) begin
                                state_d = S_RUN;
                                count_d = load_q;
                                presc_d = '0;
                                bark_d  = 1'b0;
                            end
                        end else begin
                            state_d = S_BITTEN;
                            bite_d  = 1'b1;
                        end
                    end
                end
                ADR_STATUS: begin
                    if (wb_dat_i[0]) begin
                        bark_d = 1'b0;
                        if (state_d == S_BARKED) begin
                            state_d = S_RUN;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (bus_rd) begin
            case (wb_adr_i)
                ADR_CTRL:   dat_d[2:0]       = ctrl_q;
                ADR_LOAD:   dat_d[WIDTH-1:0] = load_q;
                ADR_COUNT:  dat_d[WIDTH-1:0] = count_q;
                ADR_STATUS: dat_d[1:0]       = {bite_q, bark_q};
                default:    dat_d            = '0;
            endcase
        end

        irq_d = bark_d & ctrl_d[1];
    end

    assign wb_ack_o  = ack_q;
    assign wb_dat_o  = dat_q;
    assign irq_o     = irq_q;
    assign wdt_rst_o = bite_q;

endmodule

// File: tb/tb_wb_watchdog.sv
// Directed self-checking bench for wb_watchdog with PRESCALE=4, WIDTH=32.
module tb_wb_watchdog;

    localparam logic [31:0] KEY = 32'h5A5A_C3C3;

    logic        clk;
    logic        nrst;
    logic [2:0]  adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        irq;
    logic        wdt_rst;

    int unsigned total;
    int unsigned passed;
    int unsigned failed;
    logic [31:0] rd;

    wb_watchdog #(
        .WIDTH(32),
        .PRESCALE(4),
        .KEY(KEY)
    ) dut (
        .clk_i(clk),
        .nrst_i(nrst),
        .wb_adr_i(adr),
        .wb_dat_i(dat_i),
        .wb_dat_o(dat_o),
        .wb_we_i(we),
        .wb_cyc_i(cyc),
        .wb_stb_i(stb),
        .wb_ack_o(ack),
        .irq_o(irq),
        .wdt_rst_o(wdt_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [2:0] a, input logic [31:0] d, input logic w,
                       output logic [31:0] r);
        int unsigned n;
        @(negedge clk);
        adr = a; dat_i = d; we = w; cyc = 1'b1; stb = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ack && n < 4);
        check("bus_ack", {31'b0, ack}, 32'd1);
        r = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus(a, d, 1'b1, dummy);
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [31:0] r);
        bus(a, 32'd0, 1'b0, r);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        total = 0; passed = 0; failed = 0;

        // Reset state and register defaults
        do_reset();
        #1;
        check("rst_ack", {31'b0, ack}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_wdt", {31'b0, wdt_rst}, 32'd0);
        rd_reg(3'd1, rd); check("rst_load", rd, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check("dat_idle_zero", dat_o, 32'd0);
        rd_reg(3'd0, rd); check("rst_ctrl", rd, 32'd0);
        rd_reg(3'd4, rd); check("rst_status", rd, 32'd0);
        rd_reg(3'd2, rd); check("rst_count", rd, 32'd0);
        rd_reg(3'd3, rd); check("kick_reads0", rd, 32'd0);
        wr_reg(3'd6, 32'hDEAD_BEEF);
        rd_reg(3'd6, rd); check("adr6_reads0", rd, 32'd0);

        // Bark 12 cycles after enable, bite 12 cycles after that
        wr_reg(3'd1, 32'd3);
        wr_reg(3'd0, 32'd3);
        repeat (11) @(posedge clk);
        #1;
        check("bark_early", {31'b0, irq}, 32'd0);
        @(posedge clk); #1;
        check("bark_edge", {31'b0, irq}, 32'd1);
        check("bark_no_bite", {31'b0, wdt_rst}, 32'd0);
        rd_reg(3'd4, rd); check("bark_status", rd, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("bite_early", {31'b0, wdt_rst}, 32'd0);
        @(posedge clk); #1;
        check("bite_edge", {31'b0, wdt_rst}, 32'd1);
        rd_reg(3'd4, rd); check("bite_status", rd, 32'd3);

        // Regular kicks, each landing on a tick edge, keep the dog quiet
        do_reset();
        wr_reg(3'd1, 32'd3);
        wr_reg(3'd0, 32'd3);
        for (int i = 0; i < 37; i++) begin
            repeat (7) begin
                @(posedge clk); #1;
                check("kick_irq", {31'b0, irq}, 32'd0);
                check("kick_wdt", {31'b0, wdt_rst}, 32'd0);
            end
            wr_reg(3'd3, KEY);
        end
        rd_reg(3'd2, rd); check("kick_count", rd, 32'd3);

        // Wrong key bites on the ack edge; async reset clears it and a live ack
        do_reset();
        wr_reg(3'd0, 32'd1);
        wr_reg(3'd3, 32'h0000_1234);
        check("badkick_edge", {31'b0, wdt_rst}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("badkick_hold", {31'b0, wdt_rst}, 32'd1);
        rd_reg(3'd4, rd); check("badkick_status", rd, 32'd2);
        check("pre_rst_ack", {31'b0, ack}, 32'd1);
        nrst = 1'b0;
        #1;
        check("async_wdt", {31'b0, wdt_rst}, 32'd0);
        check("async_ack", {31'b0, ack}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;

        // LOCK freezes CTRL and LOAD, kicks still reload
        do_reset();
        wr_reg(3'd0, 32'd5);
        wr_reg(3'd0, 32'd0);
        wr_reg(3'd1, 32'd7);
        rd_reg(3'd0, rd); check("lock_ctrl", rd, 32'd5);
        rd_reg(3'd1, rd); check("lock_load", rd, 32'hFFFF_FFFF);
        rd_reg(3'd2, rd); check("lock_count_run", rd, 32'hFFFF_FFFD);
        wr_reg(3'd3, KEY);
        rd_reg(3'd2, rd); check("lock_kick_count", rd, 32'hFFFF_FFFF);

        // Clearing BARK returns to RUN so the next expiry barks again
        do_reset();
        wr_reg(3'd1, 32'd3);
        wr_reg(3'd0, 32'd3);
        repeat (12) @(posedge clk);
        #1;
        check("w1c_bark", {31'b0, irq}, 32'd1);
        wr_reg(3'd4, 32'd1);
        check("w1c_irq_low", {31'b0, irq}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("w1c_quiet", {31'b0, irq}, 32'd0);
        @(posedge clk); #1;
        check("rebark_irq", {31'b0, irq}, 32'd1);
        check("rebark_no_bite", {31'b0, wdt_rst}, 32'd0);
        rd_reg(3'd4, rd); check("rebark_status", rd, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
